// File: rtl/mdu_sched_if.sv
// Bundle types and the scheduler's bus interface for the shared multiply/divide engine.
// The master modport is the scheduler side; the slave modport is the issue/engine/commit side.
package mdu_sched_pkg;

   localparam int FUNCT_W = 4;

   typedef struct packed {
      logic [15:0] opid;
      logic [15:0] topid;
   } red_bundle_t;

   // fu[1] selects the multiply/divide unit; a[64]/b[64] pick prsv[0]/prsv[1] instead
   typedef struct packed {
      logic [15:0]        opid;
      logic [3:0]         fu;
      logic [FUNCT_W-1:0] funct;
      logic [64:0]        a;
      logic [64:0]        b;
      logic [1:0][63:0]   prsv;
      logic [7:0]         brid;
      logic [7:0]         ldid;
      logic [7:0]         stid;
      logic [63:0]        pc;
      logic [3:0]         delta;
      logic [1:0][7:0]    prda;
   } iss_bundle_t;

   typedef struct packed {
      logic [15:0] opid;
      logic [7:0]  brid;
      logic [7:0]  ldid;
      logic [7:0]  stid;
      logic [63:0] pc;
      logic [63:0] npc;
      logic [3:0]  delta;
      logic [7:0]  prda;
      logic [63:0] prdv;
      logic        misp;
      logic [7:0]  cause;
   } exe_bundle_t;

endpackage

interface mdu_sched_if #(
   parameter int ewd = 4
);
   import mdu_sched_pkg::*;

   red_bundle_t            redir;
   logic                   ready;
   iss_bundle_t [ewd-1:0]  req;
   logic                   dv_start;
   logic [63:0]            dv_a;
   logic [63:0]            dv_b;
   logic [FUNCT_W-1:0]     dv_funct;
   logic                   dv_kill;
   logic                   dv_done;
   logic [63:0]            dv_res;
   exe_bundle_t            resp;
   logic                   claim;

   modport master (
      input  redir, req, dv_done, dv_res, claim,
      output ready, dv_start, dv_a, dv_b, dv_funct, dv_kill, resp
   );

   modport slave (
      output redir, req, dv_done, dv_res, claim,
      input  ready, dv_start, dv_a, dv_b, dv_funct, dv_kill, resp
   );

endinterface

// File: rtl/mdu_sched.sv
// Shares one iterative MUL/DIV engine among ewd issue lanes via an in-order request queue.
// Optional MDU_SCHED_PERF_EN adds perf_busy/perf_squash counters.
module mdu_sched
   import mdu_sched_pkg::*;
#(
   parameter int ewd  = 4,
   parameter int opsz = 64,
   parameter int qsz  = 8
) (
   input  logic        clk,
   input  logic        rst,
`ifdef MDU_SCHED_PERF_EN
   output logic [31:0] perf_busy,
   output logic [31:0] perf_squash,
`endif
   mdu_sched_if.master bus
);

   localparam int OW = $clog2(opsz);
   localparam int QW = $clog2(qsz);
   localparam int CW = QW + 1;
   localparam logic [CW-1:0] QSZ_C = CW'(qsz);
   localparam logic [CW-1:0] EWD_C = CW'(ewd);

   typedef struct packed {
      logic [15:0] opid;
      logic [7:0]  brid;
      logic [7:0]  ldid;
      logic [7:0]  stid;
      logic [63:0] pc;
      logic [3:0]  delta;
      logic [7:0]  prda;
   } op_t;

   // Operands are resolved against prsv at enqueue so the queue holds final values
   typedef struct packed {
      op_t                info;
      logic [FUNCT_W-1:0] funct;
      logic [63:0]        a;
      logic [63:0]        b;
   } ent_t;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   // True when x is younger than the redirecting op, ages taken relative to topid
   function automatic logic squash_hit(input red_bundle_t r, input logic [15:0] x);
      logic [OW-1:0] age_x;
      logic [OW-1:0] age_r;
      age_x = x[OW-1:0] - r.topid[OW-1:0];
      age_r = r.opid[OW-1:0] - r.topid[OW-1:0];
      return r.opid[15] & x[15] & ({1'b0, age_x} >= ({1'b0, age_r} + (OW+1)'(1)));
   endfunction

   state_t                state_q, state_d;
   logic [QW-1:0]         head_q, head_d;
   logic [QW-1:0]         tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   ent_t [qsz-1:0]        mem_q, mem_d;
   logic [qsz-1:0]        bub_q, bub_d;
   op_t                   op_q, op_d;
   exe_bundle_t           resp_q, resp_d;

   logic                  pop;
   logic                  head_valid;
   logic                  head_bub;
   ent_t                  head_ent;
   logic [ewd-1:0]        lane_vld;
   logic [CW-1:0]         n_enq;
   logic [QW-1:0]         wr_idx;
   ent_t                  new_ent;
   logic                  dv_start;
   logic                  dv_kill;
   logic [63:0]           dv_a;
   logic [63:0]           dv_b;
   logic [FUNCT_W-1:0]    dv_funct;

   always_comb begin
      for (int l = 0; l < ewd; l++) begin
         lane_vld[l] = bus.req[l].opid[15] & bus.req[l].fu[1];
      end
   end

   assign head_ent   = mem_q[head_q];
   assign head_valid = (count_q != '0);
   assign head_bub   = bub_q[head_q] | squash_hit(bus.redir, head_ent.info.opid);

   // Queue update: mark squashed entries first so same-cycle enqueues stay clean
   always_comb begin
      mem_d   = mem_q;
      bub_d   = bub_q;
      n_enq   = '0;
      wr_idx  = '0;
      new_ent = '0;
      for (int i = 0; i < qsz; i++) begin
         if (squash_hit(bus.redir, mem_q[i].info.opid)) begin
            bub_d[i] = 1'b1;
         end
      end
      for (int l = 0; l < ewd; l++) begin
         if (lane_vld[l]) begin
            wr_idx             = tail_q + n_enq[QW-1:0];
            new_ent.info.opid  = bus.req[l].opid;
            new_ent.info.brid  = bus.req[l].brid;
            new_ent.info.ldid  = bus.req[l].ldid;
            new_ent.info.stid  = bus.req[l].stid;
            new_ent.info.pc    = bus.req[l].pc;
            new_ent.info.delta = bus.req[l].delta;
            new_ent.info.prda  = bus.req[l].prda[1];
            new_ent.funct      = bus.req[l].funct;
            new_ent.a          = bus.req[l].a[64] ? bus.req[l].prsv[0] : bus.req[l].a[63:0];
            new_ent.b          = bus.req[l].b[64] ? bus.req[l].prsv[1] : bus.req[l].b[63:0];
            mem_d[wr_idx]      = new_ent;
            bub_d[wr_idx]      = 1'b0;
            n_enq              = n_enq + CW'(1);
         end
      end
      tail_d  = tail_q + n_enq[QW-1:0];
      head_d  = head_q + QW'(pop);
      count_d = count_q + n_enq - CW'(pop);
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      resp_d   = resp_q;
      pop      = 1'b0;
      dv_start = 1'b0;
      dv_kill  = 1'b0;
      dv_a     = '0;
      dv_b     = '0;
      dv_funct = '0;
      case (state_q)
         IDLE: begin
            if (head_valid) begin
               pop = 1'b1;
               if (!head_bub) begin
                  dv_start = 1'b1;
                  dv_a     = head_ent.a;
                  dv_b     = head_ent.b;
                  dv_funct = head_ent.funct;
                  op_d     = head_ent.info;
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            // A redirect beats a coincident done; the engine result is discarded
            if (squash_hit(bus.redir, op_q.opid)) begin
               dv_kill = 1'b1;
               state_d = IDLE;
            end else if (bus.dv_done) begin
               resp_d       = '0;
               resp_d.opid  = op_q.opid;
               resp_d.brid  = op_q.brid;
               resp_d.ldid  = op_q.ldid;
               resp_d.stid  = op_q.stid;
               resp_d.pc    = op_q.pc;
               resp_d.delta = op_q.delta;
               resp_d.prda  = op_q.prda;
               resp_d.prdv  = bus.dv_res;
               resp_d.npc   = op_q.pc + 64'(op_q.delta);
               state_d      = HOLD;
            end
         end
         HOLD: begin
            // Claim takes priority over a squash; the consumer filters by redir itself
            if (bus.claim) begin
               resp_d  = '0;
               state_d = IDLE;
            end else if (squash_hit(bus.redir, resp_q.opid)) begin
               resp_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         bub_q   <= '0;
         op_q    <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         bub_q   <= bub_d;
         op_q    <= op_d;
         resp_q  <= resp_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.ready    = (QSZ_C - count_q) >= EWD_C;
   assign bus.dv_start = dv_start;
   assign bus.dv_kill  = dv_kill;
   assign bus.dv_a     = dv_a;
   assign bus.dv_b     = dv_b;
   assign bus.dv_funct = dv_funct;
   assign bus.resp     = resp_q;

`ifdef MDU_SCHED_PERF_EN
   logic [31:0] perf_busy_q, perf_busy_d;
   logic [31:0] perf_squash_q, perf_squash_d;
   logic        sq_evt;

   // Squash events: bubble pops, in-flight kills and dropped held results
   always_comb begin
      sq_evt = ((state_q == IDLE) & head_valid & head_bub) | dv_kill |
               ((state_q == HOLD) & ~bus.claim & squash_hit(bus.redir, resp_q.opid));
      perf_busy_d   = perf_busy_q + (((state_q == WAIT) || (state_q == HOLD)) ? 32'd1 : 32'd0);
      perf_squash_d = perf_squash_q + (sq_evt ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_busy_q   <= '0;
         perf_squash_q <= '0;
      end else begin
         perf_busy_q   <= perf_busy_d;
         perf_squash_q <= perf_squash_d;
      end
   end

   assign perf_busy   = perf_busy_q;
   assign perf_squash = perf_squash_q;
`endif

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: single op, bursts, redirects in WAIT/HOLD, order wrap and reset.
module tb_mdu_sched;
   import mdu_sched_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   mdu_sched_if #(.ewd(4)) bus ();

`ifdef MDU_SCHED_PERF_EN
   logic [31:0] perf_busy;
   logic [31:0] perf_squash;
`endif

   mdu_sched #(
      .ewd  (4),
      .opsz (64),
      .qsz  (8)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
`ifdef MDU_SCHED_PERF_EN
      .perf_busy   (perf_busy),
      .perf_squash (perf_squash),
`endif
      .bus         (bus.master)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req     = '0;
      bus.redir   = '0;
      bus.dv_done = 1'b0;
      bus.dv_res  = '0;
      bus.claim   = 1'b0;
   endtask

   task automatic set_lane(input int l, input logic [15:0] opid, input logic [64:0] a,
                           input logic [64:0] b, input logic [3:0] funct);
      bus.req[l]       = '0;
      bus.req[l].opid  = opid;
      bus.req[l].fu    = 4'b0010;
      bus.req[l].funct = funct;
      bus.req[l].a     = a;
      bus.req[l].b     = b;
      bus.req[l].pc    = 64'h4000;
      bus.req[l].delta = 4'd4;
   endtask

   task automatic set_redir(input logic [15:0] opid, input logic [15:0] topid);
      bus.redir.opid  = opid;
      bus.redir.topid = topid;
   endtask

   // Entered in a settled IDLE cycle whose head is a live op; leaves in the next IDLE cycle
   task automatic serve(input logic [15:0] exp_opid, input logic [63:0] exp_a);
      check("start", 64'(bus.dv_start), 64'd1);
      check("dv_a", bus.dv_a, exp_a);
      step();
      bus.dv_done = 1'b1;
      bus.dv_res  = exp_a * 2;
      #1;
      check("no_restart", 64'(bus.dv_start), 64'd0);
      step();
      bus.dv_done = 1'b0;
      bus.claim   = 1'b1;
      #1;
      check("resp_opid", 64'(bus.resp.opid), 64'(exp_opid));
      check("resp_prdv", bus.resp.prdv, exp_a * 2);
      step();
      bus.claim = 1'b0;
      #1;
      check("resp_cleared", 64'(bus.resp.opid), 64'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed no finish, expected finish before 100000");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_ready", 64'(bus.ready), 64'd1);
      check("rst_start", 64'(bus.dv_start), 64'd0);
      check("rst_kill", 64'(bus.dv_kill), 64'd0);
      check("rst_resp", 64'(bus.resp.opid), 64'd0);

      $display("[TB] single op on lane 2");
      set_lane(2, 16'h8005, 65'd100, 65'd7, 4'd3);
      #1;
      check("enq_ready", 64'(bus.ready), 64'd1);
      step();
      clear_inputs();
      #1;
      check("t1_start", 64'(bus.dv_start), 64'd1);
      check("t1_a", bus.dv_a, 64'd100);
      check("t1_b", bus.dv_b, 64'd7);
      check("t1_funct", 64'(bus.dv_funct), 64'd3);
      step();
      bus.dv_done = 1'b1;
      bus.dv_res  = 64'd14;
      #1;
      check("t1_wait_nostart", 64'(bus.dv_start), 64'd0);
      step();
      bus.dv_done = 1'b0;
      #1;
      check("t1_resp_opid", 64'(bus.resp.opid), 64'h8005);
      check("t1_resp_prdv", bus.resp.prdv, 64'd14);
      check("t1_resp_npc", bus.resp.npc, 64'h4004);
      step();
      #1;
      check("t1_resp_held", 64'(bus.resp.opid), 64'h8005);
      bus.claim = 1'b1;
      step();
      bus.claim = 1'b0;
      #1;
      check("t1_resp_cleared", 64'(bus.resp.opid), 64'd0);
      check("t1_idle_empty", 64'(bus.dv_start), 64'd0);

      $display("[TB] two bursts of four");
      set_lane(0, 16'h8010, 65'd1, 65'd0, 4'd1);
      set_lane(1, 16'h8011, 65'd2, 65'd0, 4'd1);
      set_lane(2, 16'h8012, 65'd3, 65'd0, 4'd1);
      set_lane(3, 16'h8013, {1'b1, 64'd4}, 65'd0, 4'd1);
      bus.req[3].prsv[0] = 64'hAA;
      #1;
      check("b1_ready", 64'(bus.ready), 64'd1);
      step();
      clear_inputs();
      set_lane(0, 16'h8014, 65'd5, 65'd0, 4'd2);
      set_lane(1, 16'h8015, 65'd6, 65'd0, 4'd2);
      set_lane(2, 16'h8016, 65'd7, 65'd0, 4'd2);
      set_lane(3, 16'h8017, 65'd8, 65'd0, 4'd2);
      #1;
      check("b2_ready", 64'(bus.ready), 64'd1);
      check("b_start0", 64'(bus.dv_start), 64'd1);
      check("b_a0", bus.dv_a, 64'd1);
      step();
      clear_inputs();
      bus.dv_done = 1'b1;
      bus.dv_res  = 64'd2;
      #1;
      check("b_full_ready", 64'(bus.ready), 64'd0);
      step();
      bus.dv_done = 1'b0;
      bus.claim   = 1'b1;
      #1;
      check("b_resp0", 64'(bus.resp.opid), 64'h8010);
      step();
      bus.claim = 1'b0;
      #1;
      serve(16'h8011, 64'd2);
      serve(16'h8012, 64'd3);
      check("b_ready_5", 64'(bus.ready), 64'd0);
      serve(16'h8013, 64'hAA);
      check("b_ready_4", 64'(bus.ready), 64'd1);
      serve(16'h8014, 64'd5);
      serve(16'h8015, 64'd6);
      serve(16'h8016, 64'd7);
      serve(16'h8017, 64'd8);
      check("b_empty", 64'(bus.dv_start), 64'd0);

      $display("[TB] redirect while waiting");
      set_lane(0, 16'h8012, 65'd9, 65'd0, 4'd1);
      set_lane(1, 16'h8013, 65'd10, 65'd0, 4'd1);
      #1;
      check("r1_enq_ready", 64'(bus.ready), 64'd1);
      step();
      clear_inputs();
      #1;
      check("r1_start", 64'(bus.dv_start), 64'd1);
      check("r1_a", bus.dv_a, 64'd9);
      step();
      set_redir(16'h8011, 16'h8000);
      bus.dv_done = 1'b1;
      bus.dv_res  = 64'd123;
      #1;
      check("r1_kill", 64'(bus.dv_kill), 64'd1);
      step();
      clear_inputs();
      #1;
      check("r1_kill_once", 64'(bus.dv_kill), 64'd0);
      check("r1_bubble_nostart", 64'(bus.dv_start), 64'd0);
      check("r1_no_resp", 64'(bus.resp.opid), 64'd0);
      step();
      #1;
      check("r1_empty", 64'(bus.dv_start), 64'd0);
      check("r1_ready", 64'(bus.ready), 64'd1);

      $display("[TB] redirect while holding");
      set_lane(0, 16'h8003, 65'd13, 65'd0, 4'd1);
      #1;
      step();
      clear_inputs();
      #1;
      check("r2_start", 64'(bus.dv_start), 64'd1);
      check("r2_a", bus.dv_a, 64'd13);
      step();
      bus.dv_done = 1'b1;
      bus.dv_res  = 64'd26;
      #1;
      step();
      bus.dv_done = 1'b0;
      set_redir(16'h8002, 16'h8000);
      #1;
      check("r2_held", 64'(bus.resp.opid), 64'h8003);
      step();
      clear_inputs();
      #1;
      check("r2_dropped", 64'(bus.resp.opid), 64'd0);
      check("r2_idle", 64'(bus.dv_start), 64'd0);
      set_lane(0, 16'h8001, 65'd11, 65'd0, 4'd1);
      #1;
      check("r2_enq_ready", 64'(bus.ready), 64'd1);
      step();
      clear_inputs();
      #1;
      check("r2_old_start", 64'(bus.dv_start), 64'd1);
      check("r2_old_a", bus.dv_a, 64'd11);
      step();
      bus.dv_done = 1'b1;
      bus.dv_res  = 64'd22;
      #1;
      step();
      bus.dv_done = 1'b0;
      set_redir(16'h8002, 16'h8000);
      #1;
      check("r2_old_resp", 64'(bus.resp.opid), 64'h8001);
      step();
      clear_inputs();
      #1;
      check("r2_old_kept", 64'(bus.resp.opid), 64'h8001);
      bus.claim = 1'b1;
      step();
      bus.claim = 1'b0;
      #1;
      check("r2_old_claimed", 64'(bus.resp.opid), 64'd0);

      $display("[TB] order index wrap");
      set_lane(1, 16'h803E, 65'h3E, 65'd0, 4'd1);
      set_lane(3, 16'h8001, 65'd1, 65'd0, 4'd1);
      #1;
      check("w_enq_ready", 64'(bus.ready), 64'd1);
      step();
      clear_inputs();
      #1;
      check("w_start", 64'(bus.dv_start), 64'd1);
      check("w_a", bus.dv_a, 64'h3E);
      step();
      set_redir(16'h803F, 16'h8030);
      #1;
      check("w_older_not_killed", 64'(bus.dv_kill), 64'd0);
      step();
      clear_inputs();
      bus.dv_done = 1'b1;
      bus.dv_res  = 64'h7C;
      #1;
      check("w_no_kill", 64'(bus.dv_kill), 64'd0);
      step();
      bus.dv_done = 1'b0;
      bus.claim   = 1'b1;
      #1;
      check("w_resp", 64'(bus.resp.opid), 64'h803E);
      check("w_prdv", bus.resp.prdv, 64'h7C);
      step();
      bus.claim = 1'b0;
      #1;
      check("w_wrapped_squashed", 64'(bus.dv_start), 64'd0);
      step();
      #1;
      check("w_empty", 64'(bus.dv_start), 64'd0);
      check("w_ready", 64'(bus.ready), 64'd1);

      $display("[TB] enqueue alongside redirect");
      set_lane(0, 16'h8025, 65'h25, 65'd0, 4'd1);
      set_redir(16'h8021, 16'h8000);
      #1;
      step();
      clear_inputs();
      #1;
      serve(16'h8025, 64'h25);

`ifdef MDU_SCHED_PERF_EN
      check("perf_squash", 64'(perf_squash), 64'd4);
      check("perf_busy", 64'(perf_busy), 64'd30);
`endif

      $display("[TB] reset while waiting");
      set_lane(0, 16'h8020, 65'd1, 65'd0, 4'd1);
      #1;
      step();
      clear_inputs();
      #1;
      check("z_start", 64'(bus.dv_start), 64'd1);
      step();
      rst = 1'b1;
      #1;
      step();
      rst = 1'b0;
      #1;
      check("z_resp", 64'(bus.resp.opid), 64'd0);
      check("z_ready", 64'(bus.ready), 64'd1);
      check("z_kill", 64'(bus.dv_kill), 64'd0);
      check("z_start_after", 64'(bus.dv_start), 64'd0);
      bus.dv_done = 1'b1;
      bus.dv_res  = 64'd5;
      step();
      bus.dv_done = 1'b0;
      #1;
      check("z_done_ignored", 64'(bus.resp.opid), 64'd0);
      check("z_still_idle", 64'(bus.dv_start), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Scheduler that shares one iterative multiply/divide engine among up to `ewd` issue lanes.
- Selects MUL/DIV requests (fu[1]) from the issue bundle and buffers them in order in a request queue.
- Sequences the external engine through a start/done handshake, squashes operations younger than a redirect, and presents one execution result at a time to the commit/PRF side with a claim handshake.

Parameters:
- ewd, 4, issue width; number of request lanes examined per cycle.
- opsz, 64, operation ID space; the order index is the low $clog2(opsz) bits of opid.
- qsz, 8, request queue depth; power of two, must be >= ewd.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- redir  input  red_bundle_t  redirect bundle (opid, topid)
- ready  output  1  high when the queue has >= ewd free entries
- req  input  iss_bundle_t[ewd-1:0]  issued requests; a lane is valid when opid[15] & fu[1]
- dv_start  output  1  one-cycle pulse launching the engine
- dv_a  output  64  operand a: prsv[0] if a[64], else a[63:0]
- dv_b  output  64  operand b: prsv[1] if b[64], else b[63:0]
- dv_funct  output  $bits(in.funct)  function code of the launched op
- dv_kill  output  1  one-cycle abort of the in-flight engine operation
- dv_done  input  1  engine result valid (single-cycle pulse)
- dv_res  input  64  engine result
- resp  output  exe_bundle_t  result; opid=0 means no result
- claim  input  1  consumer accepts resp this cycle

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values: queue empty, state IDLE, ready=1, dv_start=0, dv_kill=0, resp=0 (opid=0). Reset mid-operation discards everything and does not assert dv_kill.
- Enqueue:
  - Valid lanes are packed in lane order and written at the tail in the same cycle.
  - Requests presented while ready=0 are a protocol violation; the block's behaviour is undefined and the bench asserts on it.
  - Pointers wrap modulo qsz.
- Squash predicate for an opid x:
  - redir.opid[15] & x[15] & ((x - redir.topid) mod opsz >= (redir.opid - redir.topid) mod opsz + 1).
  - Evaluated every cycle against every queue entry, the in-flight op and the held result.
  - Squashed queue entries are marked as bubbles and skipped at the head at a rate of 1 per cycle.
  - A request enqueued in the same cycle as a redirect is not squashed by that redirect.
- FSM:
  - IDLE: if the head is valid and not a bubble, pop it, latch it into the op register, assert dv_start with operands and funct, then go to WAIT. If the head is a bubble, pop it and stay in IDLE. There is no back-to-back start in the cycle IDLE is re-entered.
  - WAIT:
    - If the squash predicate hits the op: dv_kill=1 for one cycle, then go to IDLE.
    - Else on dv_done: form the result and go to HOLD.
    - Squash and dv_done in the same cycle: squash wins, the result is dropped, and dv_kill is still pulsed.
  - HOLD:
    - resp is presented from a register.
    - claim: go to IDLE, clearing resp.opid the next cycle.
    - Squash hit: drop the result (resp.opid=0 from the next cycle), go to IDLE, no kill.
    - claim and squash in the same cycle: claim is honoured; the consumer filters by redir.
- Result formation:
  - opid/brid/ldid/stid/pc/delta/prda[1] are copied from the op.
  - prdv=dv_res; npc=pc+delta; misp=0; cause=0.
- Latency: enqueue at cycle T gives dv_start at T+1 at the earliest (queue empty, IDLE); resp is visible the cycle after dv_done.
- ready = (qsz - count) >= ewd, registered count only.
- Ordering: results are delivered in enqueue order; at most one op is in flight.

Optional Feature:
- MDU_SCHED_PERF_EN: adds outputs perf_busy[31:0] and perf_squash[31:0].
  - perf_busy counts cycles spent in WAIT or HOLD.
  - perf_squash counts squashed ops: queue bubbles popped, WAIT kills and HOLD drops.
  - Both reset to 0 and wrap at 2^32.
- Without the macro, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single op: lane 2 valid, opid=0x8005, a=100, b=7 → dv_start next cycle with dv_a=100, dv_b=7; dv_done with dv_res=14 → resp.opid=0x8005, prdv=14, held until claim.
- Burst: 4 valid lanes, opids 0x8010..0x8013 in one cycle → four dv_start pulses in opid order, ready=0 only when count > qsz-ewd (qsz=8: after a second burst of 4).
- Redirect in WAIT: in-flight opid 0x8012, queued 0x8013, redir.opid=0x8011, topid=0x8000 → dv_kill pulse, both 0x8012 and 0x8013 discarded, no resp, queue empty.
- Redirect in HOLD: held resp 0x8003, redir.opid=0x8002, topid=0x8000 → resp.opid=0 next cycle, IDLE; an older held op 0x8001 under the same redirect is kept.
- Wrap/boundary: topid=0x8030, opids 0x803E, 0x8001 (mod 64 wrap), redir.opid=0x803F → 0x8001 squashed, 0x803E completes.
- Reset in WAIT: assert rst for 1 cycle → next cycle resp.opid=0, ready=1, dv_kill=0, and a later dv_done is ignored.
